// File: rtl/sequencer_input_conditioner_pkg.sv
// sequencer_input_pkg: shared state type, default timing and counter-width helpers
package sequencer_input_pkg;
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} button_state_t;
  localparam int TICK_DIV_DEF = 1966080;
  localparam int DEBOUNCE_DEF = 655;
  localparam int REPEAT_DELAY_DEF = 16384;
  localparam int REPEAT_RATE_DEF = 4096;
  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int deb_w(int cycles);
    return cnt_w(cycles + 1);
  endfunction
  function automatic int rep_w(int delay, int rate);
    return cnt_w((delay > rate) ? delay : rate);
  endfunction
endpackage

// File: rtl/sequencer_input_conditioner_if.sv
// sequencer_input_conditioner_if: raw set buttons in, sequencer strobes out
interface sequencer_input_conditioner_if;
  logic MinButton;
  logic HourButton;
  logic Tick;
  logic SyncMinIn;
  logic SyncHourIn;
  modport master (output MinButton, HourButton, input Tick, SyncMinIn, SyncHourIn);
  modport slave (input MinButton, HourButton, output Tick, SyncMinIn, SyncHourIn);
endinterface

// File: rtl/sequencer_input_conditioner_button_conditioner.sv
// button_conditioner: synchronise, debounce and auto-repeat one raw button into single-cycle pulses
module button_conditioner
  import sequencer_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);
  localparam int DW = deb_w(DEBOUNCE_CYCLES);
  localparam int RW = rep_w(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [DW-1:0] D_END = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_RATE = RW'(REPEAT_RATE - 1);
  logic [1:0] sync_q, sync_d;
  logic [DW-1:0] d_q, d_d;
  logic [RW-1:0] r_q, r_d;
  logic lvl_q, lvl_d, pulse_q, pulse_d;
  button_state_t state_q, state_d;
  logic s;
  assign s = sync_q[1];
  assign pulse = pulse_q;
  always_comb begin
    sync_d = {sync_q[0], raw};
    d_d = (s == lvl_q || d_q == D_END) ? '0 : d_q + DW'(1);
    lvl_d = (s != lvl_q && d_q == D_END) ? s : lvl_q;
    state_d = state_q;
    r_d = r_q + RW'(1);
    pulse_d = 1'b0;
    // the FSM reacts to the level being accepted this cycle, saving a cycle of latency
    unique case (state_q)
      IDLE: begin
        r_d = '0;
        if (lvl_d && !lvl_q) begin
          state_d = HELD;
          pulse_d = 1'b1;
        end
      end
      HELD:
        if (!lvl_d) state_d = IDLE;
        else if (r_q == R_DLY) begin
          state_d = REPEAT;
          pulse_d = 1'b1;
          r_d = '0;
        end
      REPEAT:
        if (!lvl_d) state_d = IDLE;
        else if (r_q == R_RATE) begin
          pulse_d = 1'b1;
          r_d = '0;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      d_q <= '0;
      lvl_q <= 1'b0;
      state_q <= IDLE;
      r_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      d_q <= d_d;
      lvl_q <= lvl_d;
      state_q <= state_d;
      r_q <= r_d;
      pulse_q <= pulse_d;
    end
  end
endmodule

// File: rtl/sequencer_input_conditioner.sv
// sequencer_input_conditioner: one-minute prescaler plus minute/hour set-button strobes
module sequencer_input_conditioner
  import sequencer_input_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE = REPEAT_RATE_DEF
) (
  input logic Clock,
  input logic Reset,
  sequencer_input_conditioner_if.slave bus
);
  localparam int CW = cnt_w(TICK_DIV);
  localparam logic [CW-1:0] C_MAX = CW'(TICK_DIV - 1);
  logic [CW-1:0] c_q, c_d;
  logic min_pulse, hour_pulse;
  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_min (.clk(Clock), .rst(Reset), .raw(bus.MinButton), .pulse(min_pulse));
  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_hour (.clk(Clock), .rst(Reset), .raw(bus.HourButton), .pulse(hour_pulse));
  // a minute set zeroes the seconds and swallows a coincident Tick, so no minute is merged
  always_comb c_d = (min_pulse || c_q == C_MAX) ? '0 : c_q + CW'(1);
  always_ff @(posedge Clock) c_q <= Reset ? '0 : c_d;
  assign bus.Tick = (c_q == C_MAX) && !min_pulse;
  assign bus.SyncMinIn = min_pulse;
  assign bus.SyncHourIn = hour_pulse;
endmodule

// File: tb/tb_sequencer_input_conditioner.sv
// tb_sequencer_input_conditioner: directed scenarios checked cycle by cycle against a queue of expected strobes
module tb_sequencer_input_conditioner;
  typedef struct {
    int cyc;
    logic [2:0] v;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  string tag = "init";
  ev_t sb[$];
  always #5 clk = ~clk;
  sequencer_input_conditioner_if bus();
  sequencer_input_conditioner #(
    .TICK_DIV(8), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_RATE(4)
  ) dut (.Clock(clk), .Reset(rst), .bus(bus));
  localparam logic [2:0] T = 3'b100, M = 3'b010, H = 3'b001;
  task automatic check();
    logic [2:0] got, exp;
    got = {bus.Tick, bus.SyncMinIn, bus.SyncHourIn};
    exp = 3'b000;
    if (sb.size() > 0 && sb[0].cyc == cyc) exp = sb.pop_front().v;
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed {tick,min,hour}=%b expected=%b", tag, cyc, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    check();
  endtask
  task automatic run_to(int c);
    while (cyc < c) step();
  endtask
  task automatic ev(int c, logic [2:0] v);
    sb.push_back(ev_t'{c, v});
  endtask
  task automatic leftover();
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s leftover observed=%0d pending events, expected=0", tag, sb.size());
    end
    sb.delete();
  endtask
  task automatic do_reset(string name);
    leftover();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tag = name;
    cyc = 0;
    check();
  endtask
  initial begin
    #100000;
    $fatal(1, "FAIL timeout observed=no finish expected=finish by 100000");
  end
  initial begin
    bus.MinButton = 1'b0;
    bus.HourButton = 1'b0;
    do_reset("s1_free_run");
    ev(7, T); ev(15, T); ev(23, T); ev(31, T); ev(39, T);
    run_to(40);
    do_reset("s2_min_repeat");
    ev(7, T); ev(15, T); ev(16, M); ev(24, T);
    for (int k = 32; k <= 72; k += 4) ev(k, M);
    ev(80, T); ev(88, T);
    run_to(10); bus.MinButton = 1'b1;
    run_to(70); bus.MinButton = 1'b0;
    run_to(90);
    do_reset("s3_bounce");
    ev(7, T); ev(15, T); ev(20, M); ev(28, T); ev(36, T);
    run_to(10); bus.MinButton = 1'b1;
    step(); bus.MinButton = 1'b0;
    step(); bus.MinButton = 1'b1;
    step(); bus.MinButton = 1'b0;
    step(); bus.MinButton = 1'b1;
    run_to(25); bus.MinButton = 1'b0;
    run_to(40);
    do_reset("s4_collision");
    ev(7, T); ev(15, M); ev(23, T); ev(31, T); ev(39, T);
    run_to(9); bus.MinButton = 1'b1;
    run_to(21); bus.MinButton = 1'b0;
    run_to(40);
    do_reset("s5_both");
    ev(7, T); ev(15, T); ev(16, M | H); ev(24, T); ev(32, T); ev(40, T);
    run_to(10); bus.MinButton = 1'b1; bus.HourButton = 1'b1;
    run_to(20); bus.MinButton = 1'b0; bus.HourButton = 1'b0;
    run_to(41);
    do_reset("s6_hour_repeat");
    ev(7, T); ev(8, H); ev(15, T); ev(23, T); ev(24, H); ev(28, H); ev(31, T); ev(32, H);
    run_to(2); bus.HourButton = 1'b1;
    run_to(35);
    do_reset("s6_after_reset");
    ev(6, H); ev(7, T); ev(15, T); ev(22, H); ev(23, T);
    run_to(24);
    bus.HourButton = 1'b0;
    leftover();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
